// File: rtl/pc_unit.sv
// Program-counter unit: priority next-PC selection (trap > redirect > stall > RAS pop > +4)
// with a circular return-address stack and optional two-phase update gating.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4),
    parameter int              RAS_DEPTH    = 4,
    parameter bit              PHASED       = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_tock,
    input  logic            stall,
    input  logic            trap,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic             en;
    logic             do_pop;

    assign en        = PHASED ? ~tick_tock : 1'b1;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign pc_out    = pc_q;
    assign ras_top   = ras_q[ptr_q];
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == FULL_CNT);
    // Power-of-two depth lets the pointer wrap naturally, so a full push overwrites the oldest entry.
    assign ptr_inc   = ptr_q + PTR_W'(1);
    assign ptr_dec   = ptr_q - PTR_W'(1);
    assign do_pop    = ras_pop && !ras_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ras_d   = ras_q;
        if (en) begin
            if (trap) begin
                pc_d = TRAP_VECTOR;
            end else if (redirect) begin
                pc_d = redirect_pc;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (do_pop && ras_push) begin
                pc_d         = ras_top;
                ras_d[ptr_q] = pc_plus4;
            end else if (do_pop) begin
                pc_d    = ras_top;
                ptr_d   = ptr_dec;
                count_d = count_q - CNT_W'(1);
            end else begin
                pc_d = pc_plus4;
                if (ras_push) begin
                    ras_d[ptr_inc] = pc_plus4;
                    ptr_d          = ptr_inc;
                    count_d        = ras_full ? count_q : count_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the RAS array is reset too, so ras_top reads a defined 0 straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so all updates land together at the edge.
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ras_q   <= ras_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (PHASED=1, RAS_DEPTH=4): each task drives one scenario
// and compares against hand-computed values one time unit after the rising edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_tock = 1'b0;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ras_push = 1'b0;
    logic        ras_pop = 1'b0;
    logic [31:0] pc_out, pc_plus4, ras_top;
    logic        ras_empty, ras_full;

    int checks = 0;
    int failures = 0;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h4), .RAS_DEPTH(4), .PHASED(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .tick_tock(tick_tock), .stall(stall), .trap(trap),
        .redirect(redirect), .redirect_pc(redirect_pc), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns #1 after the edge with inputs idle again.
    task automatic step(input logic tt, input logic tr, input logic rd, input logic [31:0] rpc,
                        input logic st, input logic pu, input logic po);
        tick_tock = tt; trap = tr; redirect = rd; redirect_pc = rpc;
        stall = st; ras_push = pu; ras_pop = po;
        @(posedge clk);
        #1;
        tick_tock = 1'b0; trap = 1'b0; redirect = 1'b0; redirect_pc = '0;
        stall = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
        checks++;
        if ({ras_empty, ras_full} !== 2'b10) begin failures++; $display("FAIL reset_flags got=%b exp=10", {ras_empty, ras_full}); end
        checks++;
        if (ras_top !== 32'h0) begin failures++; $display("FAIL reset_top got=%h exp=0", ras_top); end
        checks++;
        if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_plus4 got=%h exp=4", pc_plus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        // tick_tock alternates 0,1,0,1...; only tick_tock==0 edges advance the PC
        for (int i = 0; i < 6; i++) begin
            step(i[0], 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (!i[0]) exp_pc = exp_pc + 32'h4;
            checks++;
            if (pc_out !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc_out, exp_pc); end
        end
        // disabled edge with trap and push asserted must change nothing
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 32'hC || ras_empty !== 1'b1) begin
            failures++; $display("FAIL phase_hold got pc=%h empty=%b exp pc=0000000c empty=1", pc_out, ras_empty);
        end
        // asynchronous reset mid-cycle, checked before the next edge
        rst = 1'b1;
        #1;
        checks++;
        if (pc_out !== 32'h0) begin failures++; $display("FAIL async_reset got=%h exp=0", pc_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h4) begin failures++; $display("FAIL post_reset_pc got=%h exp=4", pc_out); end
    endtask

    task automatic test_priority();
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h4) begin failures++; $display("FAIL prio_trap got=%h exp=4", pc_out); end
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h100) begin failures++; $display("FAIL prio_redirect got=%h exp=100", pc_out); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h100) begin failures++; $display("FAIL prio_stall got=%h exp=100", pc_out); end
        // trap with push must leave the RAS untouched
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 32'h4 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL trap_ras got pc=%h empty=%b exp pc=00000004 empty=1", pc_out, ras_empty);
        end
    endtask

    task automatic test_call_return();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ras_top !== 32'h14 || ras_empty !== 1'b0 || pc_out !== 32'h14) begin
            failures++; $display("FAIL call_push got top=%h empty=%b pc=%h exp top=00000014 empty=0 pc=00000014", ras_top, ras_empty, pc_out);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h24) begin failures++; $display("FAIL call_seq got=%h exp=24", pc_out); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pc_out !== 32'h14 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL return_pop got pc=%h empty=%b exp pc=00000014 empty=1", pc_out, ras_empty);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pops [4];
        exp_pops = '{32'h14, 32'h10, 32'hC, 32'h8};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (ras_full !== (i >= 3)) begin failures++; $display("FAIL push_full[%0d] got=%b exp=%b", i, ras_full, (i >= 3)); end
        end
        checks++;
        if (ras_top !== 32'h14 || pc_out !== 32'h14) begin
            failures++; $display("FAIL overflow_top got top=%h pc=%h exp top=00000014 pc=00000014", ras_top, pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (pc_out !== exp_pops[i]) begin failures++; $display("FAIL overflow_pop[%0d] got=%h exp=%h", i, pc_out, exp_pops[i]); end
        end
        checks++;
        if ({ras_empty, ras_full} !== 2'b10) begin failures++; $display("FAIL drained_flags got=%b exp=10", {ras_empty, ras_full}); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pc_out !== 32'hC) begin failures++; $display("FAIL empty_pop got=%h exp=c", pc_out); end
    endtask

    task automatic test_back_to_back();
        // push+pop on an empty stack behaves as push only
        do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (pc_out !== 32'h4 || ras_top !== 32'h4 || ras_empty !== 1'b0) begin
            failures++; $display("FAIL pushpop_empty got pc=%h top=%h empty=%b exp pc=00000004 top=00000004 empty=0", pc_out, ras_top, ras_empty);
        end
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (pc_out !== 32'h14 || ras_top !== 32'h34) begin
            failures++; $display("FAIL pushpop got pc=%h top=%h exp pc=00000014 top=00000034", pc_out, ras_top);
        end
        // count stayed at one: a single pop empties the stack
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (pc_out !== 32'h34 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL pushpop_count got pc=%h empty=%b exp pc=00000034 empty=1", pc_out, ras_empty);
        end
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=0", pc_plus4); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc_out); end
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pc_out !== 32'h4 || ras_top !== 32'h4 || ras_empty !== 1'b0) begin
            failures++; $display("FAIL pop_stall got pc=%h top=%h empty=%b exp pc=00000004 top=00000004 empty=0", pc_out, ras_top, ras_empty);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_call_return();
        test_overflow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined RISC-V core; it is the next generation of the single 32-bit PC register.
- Holds the fetch PC and selects the next PC by priority: trap, redirect, stall, return-address pop, sequential.
- Contains a small circular return-address stack (RAS) for call/return prediction.
- Optional two-phase (tick_tock) update gating keeps it compatible with the multi-phase pipeline timing.

Parameters:
XLEN, 32, PC / address width
RESET_VECTOR, 32'h0000_0000, pc_out value after reset
TRAP_VECTOR, 32'h0000_0004, PC loaded on trap
RAS_DEPTH, 4, RAS entries (power of 2, >=2)
PHASED, 1, 1 = update only when tick_tock==0; 0 = update every cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
tick_tock  in  1  pipeline phase; ignored when PHASED=0
stall  in  1  hold PC (hazard stall)
trap  in  1  exception; next PC = TRAP_VECTOR
redirect  in  1  branch/jump resolved; next PC = redirect_pc
redirect_pc  in  XLEN  redirect target
ras_push  in  1  current fetch is a call; push pc_out+4
ras_pop  in  1  current fetch is a return; predict from RAS
pc_out  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc_out+4 (combinational)
ras_top  out  XLEN  top RAS entry (undefined contents when empty)
ras_empty  out  1  RAS count==0
ras_full  out  1  RAS count==RAS_DEPTH

Behaviour:
- Reset (async, immediate):
  - pc_out=RESET_VECTOR.
  - RAS count=0, pointer=0, entries cleared to 0.
  - ras_empty=1, ras_full=0.
- Update enable: en = PHASED ? ~tick_tock : 1. When en=0, no state changes (PC and RAS hold) regardless of other inputs.
- Next-PC priority when en=1, highest first:
  1. trap: pc <= TRAP_VECTOR. RAS untouched.
  2. redirect: pc <= redirect_pc. RAS untouched.
  3. stall: pc holds. RAS untouched.
  4. ras_pop with RAS non-empty: pc <= ras_top.
  5. Otherwise: pc <= pc_out+4.
- Arithmetic: +4 is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- Latency: PC and RAS changes are visible the cycle after the enabled edge. pc_plus4 is combinational from pc_out.
- RAS operations (only on en=1 cycles with no trap, redirect or stall):
  - push only: write pc_out+4 at ptr+1, ptr++, count = min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry (pointer wraps modulo RAS_DEPTH); count stays RAS_DEPTH; ras_full stays 1.
  - pop only, non-empty: ptr--, count--.
  - pop when empty: ignored; PC takes the sequential value.
  - push+pop same cycle, non-empty: next pc = old top; top entry overwritten with pc_out+4; ptr and count unchanged.
  - push+pop same cycle, empty: treated as push only; PC sequential.
- ras_top = entry[ptr]; ras_empty and ras_full are derived combinationally from count.
- Reset asserted mid-operation: PC and RAS return to reset values asynchronously. The first update occurs on the first enabled edge after rst deasserts.

Test Plan:
- Reset/sequential (PHASED=1): rst pulse, then tick_tock toggling each cycle -> pc_out=0 after reset; then 4, 8, C, advancing only on edges where tick_tock==0. Assert rst mid-run -> pc_out=0 immediately, without waiting for a clock edge.
- Priority: at pc=0x40, assert trap+redirect(0x100)+stall together -> pc=0x4. Next enabled cycle redirect(0x100)+stall -> pc=0x100. Next cycle stall only -> pc holds 0x100.
- Call/return: push at pc=0x10 -> ras_top=0x14, count 1. Sequential to 0x24, then pop -> pc=0x14, ras_empty=1.
- Overflow (RAS_DEPTH=4): five pushes at pc 0x0,0x4,0x8,0xC,0x10 -> ras_full=1. Four pops yield 0x14, 0x10, 0xC, 0x8 (0x4 lost). A fifth pop is ignored -> PC sequential.
- Simultaneous/edge: push+pop at pc=0x30 with top=0x14 -> pc=0x14, top becomes 0x34, count unchanged. pc=0xFFFF_FFFC sequential -> pc=0x0. Pop with stall -> PC and RAS unchanged.
